cmd_req_sequencer: RTL and testbench

Upstream command producer for the MIB command path. It accepts register read/write requests on a valid/ready request stream and issues exactly one outstanding command at a time on an `intf_cmd` master port, which connects directly to the system-side command slave of the clock-domain-crossing stage. It waits for `ack`, enforces a timeout, flushes late acknowledgements, and returns one response per request on a valid/ready response stream. Everything runs in the system clock domain.

---
 rtl/cmd_req_sequencer_if.sv | 24 ++
 rtl/cmd_req_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_cmd_req_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_req_sequencer_if.sv
// Command port between the request sequencer (master) and the
// system-side command slave of the clock-domain-crossing stage.
`timescale 1ns/1ps
interface intf_cmd #(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 32
) ();
    logic                 sel;
    logic                 rd_wr_n;
    logic [ADDR_BITS-1:0] byte_addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 ack;
    logic [DATA_BITS-1:0] rdata;

    modport master (
        output sel, rd_wr_n, byte_addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  sel, rd_wr_n, byte_addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/cmd_req_sequencer.sv
// Single-outstanding command sequencer: request stream in, one intf_cmd command out,
// ack/timeout/flush handling, one response per request. Stats gated by CMD_REQ_SEQUENCER_STATS_EN.
`timescale 1ns/1ps
module cmd_req_sequencer #(
    parameter int ADDR_BITS      = 24,
    parameter int DATA_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FLUSH_CYCLES   = 256
) (
    input  logic                 i_sys_clk,
    input  logic                 i_sys_arst,
    // Streams transfer on a clock edge where valid and ready are both high;
    // valid and its payload stay stable until then, ready never depends on valid.
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_rd_wr_n,
    input  logic [ADDR_BITS-1:0] i_req_addr,
    input  logic [DATA_BITS-1:0] i_req_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [DATA_BITS-1:0] o_rsp_rdata,
    output logic                 o_rsp_timeout,
    output logic                 o_rsp_misalign,
    intf_cmd.master              cmd,
    output logic [31:0]          o_stat_txn_cnt,
    output logic [15:0]          o_stat_timeout_cnt,
    output logic [15:0]          o_stat_late_ack_cnt,
    output logic [2:0]           o_dbg_state
);
    localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_ACK = 3'd2,
        FLUSH    = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 alive_q;
    logic                 rd_wr_n_q, rd_wr_n_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic                 rsp_misalign_q, rsp_misalign_d;

    always_ff @(posedge i_sys_clk or posedge i_sys_arst) begin
        if (i_sys_arst) begin
            state_q        <= IDLE;
            alive_q        <= 1'b0;
            rd_wr_n_q      <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wait_cnt_q     <= '0;
            flush_cnt_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_timeout_q  <= 1'b0;
            rsp_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            alive_q        <= 1'b1;
            rd_wr_n_q      <= rd_wr_n_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wait_cnt_q     <= wait_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_timeout_q  <= rsp_timeout_d;
            rsp_misalign_q <= rsp_misalign_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rd_wr_n_d      = rd_wr_n_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wait_cnt_d     = wait_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_timeout_d  = rsp_timeout_q;
        rsp_misalign_d = rsp_misalign_q;
        case (state_q)
            IDLE: begin
                if (alive_q && i_req_valid) begin
                    rd_wr_n_d = i_req_rd_wr_n;
                    addr_d    = i_req_addr;
                    wdata_d   = i_req_wdata;
                    if (i_req_addr[1:0] != 2'b00) begin
                        state_d        = RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_rdata_d    = '0;
                        rsp_timeout_d  = 1'b0;
                        rsp_misalign_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            // An ack arriving in the same cycle as sel is already a valid completion.
            ISSUE, WAIT_ACK: begin
                if (cmd.ack) begin
                    state_d        = RESP;
                    wait_cnt_d     = '0;
                    rsp_valid_d    = 1'b1;
                    rsp_rdata_d    = rd_wr_n_q ? cmd.rdata : '0;
                    rsp_timeout_d  = 1'b0;
                    rsp_misalign_d = 1'b0;
                end else if (state_q == ISSUE) begin
                    state_d    = WAIT_ACK;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = FLUSH;
                    wait_cnt_d  = '0;
                    flush_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                    state_d        = RESP;
                    flush_cnt_d    = '0;
                    rsp_valid_d    = 1'b1;
                    rsp_rdata_d    = '0;
                    rsp_timeout_d  = 1'b1;
                    rsp_misalign_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d        = IDLE;
                    rsp_valid_d    = 1'b0;
                    rsp_rdata_d    = '0;
                    rsp_timeout_d  = 1'b0;
                    rsp_misalign_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command fields are zero whenever no command is on the bus.
    assign cmd.sel       = (state_q == ISSUE);
    assign cmd.rd_wr_n   = cmd.sel & rd_wr_n_q;
    assign cmd.byte_addr = cmd.sel ? addr_q : '0;
    assign cmd.wdata     = cmd.sel ? wdata_q : '0;

    assign o_req_ready    = alive_q && (state_q == IDLE);
    assign o_rsp_valid    = rsp_valid_q;
    assign o_rsp_rdata    = rsp_rdata_q;
    assign o_rsp_timeout  = rsp_timeout_q;
    assign o_rsp_misalign = rsp_misalign_q;
    assign o_dbg_state    = state_q;

`ifdef CMD_REQ_SEQUENCER_STATS_EN
    logic stat_issue, stat_to_flush, stat_late_ack;
    assign stat_issue    = (state_q == ISSUE);
    assign stat_to_flush = (state_q == WAIT_ACK) && !cmd.ack &&
                           (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign stat_late_ack = cmd.ack &&
                           ((state_q == IDLE) || (state_q == FLUSH) || (state_q == RESP));

    // Saturating counters: they stick at all-ones rather than wrap.
    always_ff @(posedge i_sys_clk or posedge i_sys_arst) begin
        if (i_sys_arst) begin
            o_stat_txn_cnt      <= '0;
            o_stat_timeout_cnt  <= '0;
            o_stat_late_ack_cnt <= '0;
        end else begin
            if (stat_issue && (o_stat_txn_cnt != '1))
                o_stat_txn_cnt <= o_stat_txn_cnt + 1'b1;
            if (stat_to_flush && (o_stat_timeout_cnt != '1))
                o_stat_timeout_cnt <= o_stat_timeout_cnt + 1'b1;
            if (stat_late_ack && (o_stat_late_ack_cnt != '1))
                o_stat_late_ack_cnt <= o_stat_late_ack_cnt + 1'b1;
        end
    end
`else
    assign o_stat_txn_cnt      = '0;
    assign o_stat_timeout_cnt  = '0;
    assign o_stat_late_ack_cnt = '0;
`endif
endmodule

// File: tb/tb_cmd_req_sequencer.sv
// Directed self-checking bench for cmd_req_sequencer with a registered-latency command slave.
`timescale 1ns/1ps
module tb_cmd_req_sequencer;
  localparam int AW = 24;
  localparam int DW = 32;
`ifdef CMD_REQ_SEQUENCER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rd = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_timeout, rsp_misalign;
  logic [31:0]   stat_txn;
  logic [15:0]   stat_to, stat_late;
  logic [2:0]    dbg_state;

  intf_cmd #(.ADDR_BITS(AW), .DATA_BITS(DW)) cmd_if ();

  cmd_req_sequencer #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(8), .FLUSH_CYCLES(4)
  ) dut (
    .i_sys_clk(clk), .i_sys_arst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_rd_wr_n(req_rd),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_timeout(rsp_timeout), .o_rsp_misalign(rsp_misalign),
    .cmd(cmd_if.master),
    .o_stat_txn_cnt(stat_txn), .o_stat_timeout_cnt(stat_to), .o_stat_late_ack_cnt(stat_late),
    .o_dbg_state(dbg_state)
  );

  // command slave: registers sel, then raises ack for one cycle slave_lat cycles later
  int            slave_lat = -1;
  logic          slave_use_addr = 1'b0;
  logic [DW-1:0] slave_rdata = '0;
  logic [DW-1:0] slave_d;
  logic          ack_slave = 1'b0;
  logic          ack_inj = 1'b0;
  assign cmd_if.ack = ack_slave | ack_inj;

  initial begin
    cmd_if.rdata = '0;
    forever begin
      @(negedge clk);
      if (cmd_if.sel && slave_lat >= 0) begin
        slave_d = slave_use_addr ? {8'hC0, cmd_if.byte_addr} : slave_rdata;
        repeat (slave_lat + 1) @(negedge clk);
        ack_slave = 1'b1;
        cmd_if.rdata = slave_d;
        @(negedge clk);
        ack_slave = 1'b0;
        cmd_if.rdata = '0;
      end
    end
  end

  // sel monitor
  int            sel_cnt = 0;
  int            sel_cyc = 0;
  logic          sel_rd = 1'b0;
  logic [AW-1:0] sel_addr = '0;
  logic [DW-1:0] sel_wdata = '0;
  always @(negedge clk) begin
    if (cmd_if.sel) begin
      sel_cnt++;
      sel_cyc   = cyc;
      sel_rd    = cmd_if.rd_wr_n;
      sel_addr  = cmd_if.byte_addr;
      sel_wdata = cmd_if.wdata;
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  // driver tasks (called at a falling edge)
  task automatic send_req(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    logic ok;
    ok = 1'b0;
    req_rd = rd; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("req_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input int budget, output int at);
    logic seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid) begin seen = 1'b1; at = cyc; break; end
      @(negedge clk);
    end
    check_eq("rsp_seen", 32'(seen), 32'd1);
  endtask

  task automatic rsp_take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int at, n0, nsel, nrsp;
    int sel_at[3];
    logic [DW-1:0] e;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_sel", 32'(cmd_if.sel), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    check_eq("rst_txn", stat_txn, 32'd0);
    rst = 1'b0;
    check_eq("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("ready_after_rst", 32'(req_ready), 32'd1);

    // write, ack 6 cycles after sel; rdata must be forced to 0
    slave_lat = 6; slave_use_addr = 1'b0; slave_rdata = 32'hDEAD_BEEF;
    n0 = sel_cnt;
    send_req(1'b0, 24'h000010, 32'hA5A5_5A5A);
    wait_rsp(40, at);
    check_eq("wr_sel_cnt", 32'(sel_cnt - n0), 32'd1);
    check_eq("wr_sel_addr", 32'(sel_addr), 32'h10);
    check_eq("wr_sel_wdata", sel_wdata, 32'hA5A5_5A5A);
    check_eq("wr_sel_rd", 32'(sel_rd), 32'd0);
    check_eq("wr_rdata", rsp_rdata, 32'd0);
    check_eq("wr_timeout", 32'(rsp_timeout), 32'd0);
    check_eq("wr_misalign", 32'(rsp_misalign), 32'd0);
    check_eq("wr_txn", stat_txn, st(1));
    rsp_take();
    check_eq("wr_rsp_drop", 32'(rsp_valid), 32'd0);

    // read with back-pressured response
    slave_lat = 3; slave_rdata = 32'h1234_5678;
    send_req(1'b1, 24'h000104, 32'h0);
    wait_rsp(40, at);
    check_eq("rd_sel_rd", 32'(sel_rd), 32'd1);
    check_eq("rd_sel_addr", 32'(sel_addr), 32'h104);
    check_eq("rd_rdata", rsp_rdata, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rd_hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("rd_hold_rdata", rsp_rdata, 32'h1234_5678);
    end
    rsp_take();
    check_eq("rd_rsp_drop", 32'(rsp_valid), 32'd0);
    check_eq("rd_ready_back", 32'(req_ready), 32'd1);

    // misaligned read: no command, immediate error response
    n0 = sel_cnt;
    send_req(1'b1, 24'h000006, 32'h0);
    check_eq("mis_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("mis_flag", 32'(rsp_misalign), 32'd1);
    check_eq("mis_rdata", rsp_rdata, 32'd0);
    check_eq("mis_timeout", 32'(rsp_timeout), 32'd0);
    check_eq("mis_state", 32'(dbg_state), 32'd4);
    rsp_take();
    repeat (3) @(negedge clk);
    check_eq("mis_no_sel", 32'(sel_cnt - n0), 32'd0);

    // timeout with a stray ack during flush
    slave_lat = -1;
    send_req(1'b1, 24'h000020, 32'h0);
    check_eq("to_sel_now", 32'(cmd_if.sel), 32'd1);
    repeat (11) @(negedge clk);
    check_eq("to_in_flush", 32'(dbg_state), 32'd3);
    ack_inj = 1'b1;
    @(negedge clk);
    ack_inj = 1'b0;
    wait_rsp(40, at);
    check_eq("to_latency", 32'(at - sel_cyc), 32'd13);
    check_eq("to_flag", 32'(rsp_timeout), 32'd1);
    check_eq("to_rdata", rsp_rdata, 32'd0);
    check_eq("to_misalign", 32'(rsp_misalign), 32'd0);
    check_eq("to_cnt", 32'(stat_to), st(1));
    check_eq("to_late_cnt", 32'(stat_late), st(1));
    rsp_take();
    slave_lat = 1; slave_rdata = 32'h0BAD_F00D;
    send_req(1'b1, 24'h000024, 32'h0);
    wait_rsp(40, at);
    check_eq("after_to_rdata", rsp_rdata, 32'h0BAD_F00D);
    check_eq("after_to_flag", 32'(rsp_timeout), 32'd0);
    check_eq("after_to_txn", stat_txn, st(4));
    rsp_take();

    // asynchronous reset while waiting for ack
    slave_lat = -1;
    send_req(1'b1, 24'h000040, 32'h0);
    repeat (2) @(negedge clk);
    check_eq("ar_wait_state", 32'(dbg_state), 32'd2);
    n0 = sel_cnt;
    #2 rst = 1'b1;
    #1;
    check_eq("ar_sel", 32'(cmd_if.sel), 32'd0);
    check_eq("ar_addr", 32'(cmd_if.byte_addr), 32'd0);
    check_eq("ar_ready", 32'(req_ready), 32'd0);
    check_eq("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("ar_state", 32'(dbg_state), 32'd0);
    check_eq("ar_txn", stat_txn, 32'd0);
    check_eq("ar_to_cnt", 32'(stat_to), 32'd0);
    check_eq("ar_late_cnt", 32'(stat_late), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ack_inj = 1'b1;
    @(negedge clk);
    ack_inj = 1'b0;
    check_eq("ar_late_after", 32'(stat_late), st(1));
    check_eq("ar_no_sel", 32'(sel_cnt - n0), 32'd0);
    check_eq("ar_no_rsp", 32'(rsp_valid), 32'd0);
    slave_lat = 1; slave_rdata = 32'h5555_AAAA;
    send_req(1'b0, 24'h000050, 32'h1111_2222);
    wait_rsp(40, at);
    check_eq("ar_fresh_addr", 32'(sel_addr), 32'h50);
    check_eq("ar_fresh_rdata", rsp_rdata, 32'd0);
    check_eq("ar_fresh_flags", {30'd0, rsp_timeout, rsp_misalign}, 32'd0);
    check_eq("ar_fresh_txn", stat_txn, st(1));
    rsp_take();

    // back-to-back reads, valid and rsp_ready held high, slave latency 2
    slave_lat = 2; slave_use_addr = 1'b1;
    exp_q.push_back(32'hC000_0100);
    exp_q.push_back(32'hC000_0104);
    exp_q.push_back(32'hC000_0108);
    nsel = 0; nrsp = 0;
    rsp_ready = 1'b1;
    req_rd = 1'b1; req_addr = 24'h000100; req_valid = 1'b1;
    for (int i = 0; i < 60 && nrsp < 3; i++) begin
      @(negedge clk);
      if (cmd_if.sel) begin
        if (nsel < 3) sel_at[nsel] = cyc;
        nsel++;
        if (nsel < 3) req_addr = 24'h000100 + 24'(4 * nsel);
        else req_valid = 1'b0;
      end
      if (rsp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check_eq("b2b_rdata", rsp_rdata, e);
        nrsp++;
      end
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("b2b_nsel", 32'(nsel), 32'd3);
    check_eq("b2b_nrsp", 32'(nrsp), 32'd3);
    check_eq("b2b_gap0", 32'(sel_at[1] - sel_at[0]), 32'd6);
    check_eq("b2b_gap1", 32'(sel_at[2] - sel_at[1]), 32'd6);
    check_eq("b2b_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("b2b_txn", stat_txn, st(4));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
